// File: rtl/tdm_slot_timer_if.sv
// Bus bundle for the TDM slot sequencer.
//
// Purpose: groups the control, configuration and status signals of
// tdm_slot_timer so one handle connects the controller to the sequencer.
//
// Handshake semantics: there is no valid/ready pair on this bus.
//   - start is a level that is sampled only while the sequencer is idle.
//     It has no acknowledge. The controller sees acceptance as busy going
//     high one cycle later.
//   - stop is a level that is sampled every cycle. It wins over start.
//   - cfg_we/cfg_ch/cfg_len is a fire-and-forget write. It is accepted in
//     every cycle in which cfg_we is high.
//
// Signals (direction as seen by the sequencer, modport slave):
//   start, stop          in   frame control
//   cfg_we, cfg_ch,      in   slot-length table write port
//   cfg_len
//   busy                 out  sequencer is running a frame
//   slot                 out  active channel index
//   count                out  remaining count in the current slot
//   slot_start           out  first cycle of a slot
//   slot_tc              out  terminal cycle of a slot
//   frame_done           out  terminal cycle of the last channel
//   state                out  debug view of the FSM (0 = IDLE, 1 = RUN)
interface tdm_slot_timer_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              start;
  logic              stop;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_len;
  logic              busy;
  logic [CH_W-1:0]   slot;
  logic [CNT_W-1:0]  count;
  logic              slot_start;
  logic              slot_tc;
  logic              frame_done;
  logic              state;

  modport master (
    output start, stop, cfg_we, cfg_ch, cfg_len,
    input  busy, slot, count, slot_start, slot_tc, frame_done, state
  );

  modport slave (
    input  start, stop, cfg_we, cfg_ch, cfg_len,
    output busy, slot, count, slot_start, slot_tc, frame_done, state
  );
endinterface

// File: rtl/tdm_slot_timer.sv
// Multi-channel TDM slot sequencer.
//
// Purpose: holds a programmable length for each channel. It walks through
// channels 0..N_CH-1 and counts each slot down to zero. It flags slot start,
// slot terminal cycle and frame end for the downstream burst muxes.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset. It also restores the length
//               table to DEFAULT_LEN.
//   bus    slave modport of tdm_slot_timer_if (control, config, status)
//
// Every status output is a register, or a decode of registers only
// (slot_tc, frame_done). No input reaches an output combinationally.
module tdm_slot_timer #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 8,
  parameter int DEFAULT_LEN  = 255,
  parameter bit AUTO_RESTART = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdm_slot_timer_if.slave      bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEFAULT_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              slot_start_q, slot_start_d;
  logic [CNT_W-1:0]  len_q [N_CH];

  logic [CH_W-1:0]   next_slot;
  logic              cfg_hit;

  assign next_slot = slot_q + 1'b1;
  // Writes to channel indices beyond the table are dropped.
  assign cfg_hit   = bus.cfg_we && (int'(bus.cfg_ch) < N_CH);

  // Next-state logic. Reloads read len_q, which is the pre-write value.
  // A config write in the same cycle as a reload therefore only affects
  // the next load of that channel.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    count_d      = count_q;
    slot_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d      = RUN;
          slot_d       = '0;
          count_d      = len_q[0];
          slot_start_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          slot_d  = '0;
          count_d = '0;
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (slot_q != LAST_CH) begin
          slot_d       = next_slot;
          count_d      = len_q[next_slot];
          slot_start_d = 1'b1;
        end else if (AUTO_RESTART) begin
          // Back-to-back frames. Channel 0 starts in the cycle right
          // after frame_done.
          slot_d       = '0;
          count_d      = len_q[0];
          slot_start_d = 1'b1;
        end else begin
          state_d = IDLE;
          slot_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      count_q      <= '0;
      slot_start_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        len_q[i] <= DEF_LEN;
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      count_q      <= count_d;
      slot_start_q <= slot_start_d;
      if (cfg_hit) begin
        len_q[bus.cfg_ch] <= bus.cfg_len;
      end
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.slot       = slot_q;
  assign bus.count      = count_q;
  assign bus.slot_start = slot_start_q;
  assign bus.slot_tc    = (state_q == RUN) && (count_q == '0);
  assign bus.frame_done = (state_q == RUN) && (count_q == '0) && (slot_q == LAST_CH);
  assign bus.state      = state_q;
endmodule
